// File: rtl/uart_frame_scheduler.sv
// Shares one byte-level UART transmitter between a periodic status-snapshot frame
// and single-byte event frames: HEADER, TYPE, payload, XOR checksum over a valid/ready link.
module uart_frame_scheduler #(
  parameter int unsigned PERIOD_CYCLES = 10000000,
  parameter logic [7:0]  HEADER        = 8'hA5,
  parameter int unsigned CNT_W         = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [111:0] status_bus,
  input  logic         evt_req,
  input  logic [7:0]   evt_code,
  output logic         evt_ack,
  output logic         evt_dropped,
  output logic         status_overrun,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         busy,
  output logic         frame_done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_TYPE    = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CSUM    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PERIOD_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [7:0]       TYPE_STAT = 8'h01;
  localparam logic [7:0]       TYPE_EVT  = 8'h02;
  localparam logic [3:0]       LAST_IDX  = 4'd13;

  // XOR of all 14 payload byte lanes; event payloads occupy lane 0 only.
  function automatic logic [7:0] xor_bytes(input logic [111:0] bytes);
    logic [7:0] acc;
    acc = 8'h00;
    for (int k = 0; k < 14; k++) begin
      acc = acc ^ bytes[8*k +: 8];
    end
    return acc;
  endfunction

  state_t         state_r;
  logic [CNT_W-1:0] cnt_r;
  logic           stat_pend_r;
  logic           evt_pend_r;
  logic [7:0]     evt_code_r;
  logic           last_was_evt_r;
  logic [111:0]   frame_r;
  logic           is_evt_r;
  logic [3:0]     idx_r;
  logic [7:0]     csum_r;

  logic           wrap_s;
  logic           idle_go_s;
  logic           pick_evt_s;
  logic           pick_stat_s;
  logic           hold_free_s;
  logic           evt_ack_s;
  logic           evt_drop_s;
  logic           xfer_s;
  logic [111:0]   payload_s;
  logic [7:0]     type_s;
  logic [3:0]     nidx_s;
  logic [111:0]   shifted_s;
  logic [7:0]     next_byte_s;

  assign wrap_s      = enable && (cnt_r == CNT_LAST);
  assign idle_go_s   = (state_r == S_IDLE) && enable;
  // Events win a tie unless the previous frame was also an event.
  assign pick_evt_s  = idle_go_s && evt_pend_r && (!stat_pend_r || !last_was_evt_r);
  assign pick_stat_s = idle_go_s && stat_pend_r && (!evt_pend_r || last_was_evt_r);
  assign hold_free_s = !evt_pend_r || pick_evt_s;
  assign evt_ack_s   = evt_req && hold_free_s;
  assign evt_drop_s  = evt_req && !hold_free_s;
  assign evt_ack     = evt_ack_s && !rst;
  assign evt_dropped = evt_drop_s && !rst;
  assign xfer_s      = tx_valid && tx_ready;
  assign payload_s   = pick_evt_s ? {104'd0, evt_code_r} : status_bus;
  assign type_s      = pick_evt_s ? TYPE_EVT : TYPE_STAT;
  assign nidx_s      = idx_r + 4'd1;
  assign shifted_s   = frame_r >> {nidx_s, 3'b000};
  assign next_byte_s = shifted_s[7:0];

  // Period timer, status/event pending flags and the one-entry event holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r          <= {CNT_W{1'b0}};
      stat_pend_r    <= 1'b0;
      evt_pend_r     <= 1'b0;
      evt_code_r     <= 8'h00;
      status_overrun <= 1'b0;
    end else begin
      if (!enable) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (wrap_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end

      status_overrun <= wrap_s && stat_pend_r;

      // A wrap coinciding with a status start re-arms the flag for the next frame.
      if (wrap_s) begin
        stat_pend_r <= 1'b1;
      end else if (pick_stat_s) begin
        stat_pend_r <= 1'b0;
      end else begin
        stat_pend_r <= stat_pend_r;
      end

      if (evt_ack_s) begin
        evt_pend_r <= 1'b1;
        evt_code_r <= evt_code;
      end else if (pick_evt_s) begin
        evt_pend_r <= 1'b0;
      end else begin
        evt_pend_r <= evt_pend_r;
      end
    end
  end

  // Frame sequencer: snapshots the payload at frame start and presents one byte per state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= S_IDLE;
      tx_data        <= 8'h00;
      tx_valid       <= 1'b0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      frame_r        <= 112'd0;
      is_evt_r       <= 1'b0;
      idx_r          <= 4'd0;
      csum_r         <= 8'h00;
      last_was_evt_r <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (pick_evt_s || pick_stat_s) begin
            frame_r        <= payload_s;
            is_evt_r       <= pick_evt_s;
            last_was_evt_r <= pick_evt_s;
            csum_r         <= type_s ^ xor_bytes(payload_s);
            idx_r          <= 4'd0;
            tx_data        <= HEADER;
            tx_valid       <= 1'b1;
            busy           <= 1'b1;
            state_r        <= S_HDR;
          end
        end
        S_HDR: begin
          if (xfer_s) begin
            tx_data <= is_evt_r ? TYPE_EVT : TYPE_STAT;
            state_r <= S_TYPE;
          end
        end
        S_TYPE: begin
          if (xfer_s) begin
            tx_data <= frame_r[7:0];
            idx_r   <= 4'd0;
            state_r <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (xfer_s) begin
            if (is_evt_r || (idx_r == LAST_IDX)) begin
              tx_data <= csum_r;
              state_r <= S_CSUM;
            end else begin
              idx_r   <= nidx_s;
              tx_data <= next_byte_s;
            end
          end
        end
        S_CSUM: begin
          if (xfer_s) begin
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            state_r    <= S_IDLE;
          end
        end
        default: begin
          tx_data  <= 8'h00;
          tx_valid <= 1'b0;
          busy     <= 1'b0;
          state_r  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Directed bench for uart_frame_scheduler: status and event frames, arbitration,
// holding-register overflow, stalls and mid-frame reset.
module tb_uart_frame_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [111:0] status_bus;
  logic         evt_req;
  logic [7:0]   evt_code;
  logic         evt_ack;
  logic         evt_dropped;
  logic         status_overrun;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         busy;
  logic         frame_done;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [7:0]   cap [0:31];
  logic [7:0]   exp_b [0:31];
  int           cap_n, done_n, busy_n, w, ovr, bad;
  logic         busy_post;
  logic [111:0] pat1, pat2, pat3;

  always #5 clk = ~clk;

  uart_frame_scheduler #(
    .PERIOD_CYCLES(20),
    .HEADER       (8'hA5),
    .CNT_W        (5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .status_bus    (status_bus),
    .evt_req       (evt_req),
    .evt_code      (evt_code),
    .evt_ack       (evt_ack),
    .evt_dropped   (evt_dropped),
    .status_overrun(status_overrun),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic build_status(input logic [111:0] sb);
    logic [7:0] acc;
    exp_b[0] = 8'hA5;
    exp_b[1] = 8'h01;
    acc = 8'h01;
    for (int k = 0; k < 14; k++) begin
      exp_b[2+k] = sb[8*k +: 8];
      acc = acc ^ sb[8*k +: 8];
    end
    exp_b[16] = acc;
  endtask

  task automatic build_evt(input logic [7:0] code);
    exp_b[0] = 8'hA5;
    exp_b[1] = 8'h02;
    exp_b[2] = code;
    exp_b[3] = 8'h02 ^ code;
  endtask

  task automatic wait_valid();
    w = 0;
    while (!tx_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
  endtask

  // Called at a negedge; drives tx_ready per cycle and records every transferred byte.
  task automatic collect(input int n, input bit rnd);
    int         guard;
    logic       stalled;
    logic [7:0] held;
    cap_n = 0; done_n = 0; busy_n = 0; guard = 0;
    stalled = 1'b0; held = 8'h00;
    while (cap_n < n && guard < 400) begin
      if (stalled) check("stall_hold", 32'({tx_valid, tx_data}), 32'({1'b1, held}));
      if (busy) busy_n++;
      if (frame_done) done_n++;
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tx_valid && tx_ready) begin
        cap[cap_n] = tx_data;
        cap_n++;
      end
      stalled = tx_valid && !tx_ready;
      held = tx_data;
      @(negedge clk);
      guard++;
    end
    if (frame_done) done_n++;
    busy_post = busy;
    tx_ready = 1'b1;
  endtask

  task automatic verify(input string tag, input int n);
    check({tag, "_len"}, 32'(cap_n), 32'(n));
    for (int i = 0; i < n && i < cap_n; i++) begin
      check($sformatf("%s_b%0d", tag, i), 32'(cap[i]), 32'(exp_b[i]));
    end
    check({tag, "_done"}, 32'(done_n), 32'd1);
    check({tag, "_idle"}, 32'(busy_post), 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 14; k++) begin
      pat1[8*k +: 8] = 8'(k + 1);
      pat3[8*k +: 8] = 8'(8'h30 + 3*k);
    end
    pat2 = ~pat1;

    rst = 1'b1; enable = 1'b0; evt_req = 1'b0; evt_code = 8'h00;
    tx_ready = 1'b0; status_bus = pat1;
    repeat (3) @(negedge clk);
    check("rst_outs", 32'({tx_valid, busy, frame_done, evt_ack, evt_dropped, status_overrun}), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 32'({tx_valid, busy, frame_done}), 32'd0);

    // Status frame after the first period wrap; the bus changes after start.
    enable = 1'b1;
    wait_valid();
    check("t1_latency", 32'(w), 32'd21);
    status_bus = pat2;
    enable = 1'b0;
    collect(17, 1'b0);
    build_status(pat1);
    verify("t1", 17);
    check("t1_csum", 32'(cap[16]), 32'h0E);
    check("t1_busy", 32'(busy_n), 32'd17);

    // Event frame from idle.
    evt_code = 8'h3C; evt_req = 1'b1; enable = 1'b1;
    #1;
    check("t2_ack", 32'({evt_ack, evt_dropped}), 32'b10);
    @(negedge clk);
    evt_req = 1'b0;
    check("t2_lat0", 32'(tx_valid), 32'd0);
    @(negedge clk);
    check("t2_lat1", 32'(tx_valid), 32'd1);
    enable = 1'b0;
    collect(4, 1'b0);
    build_evt(8'h3C);
    verify("t2", 4);
    check("t2_csum", 32'(cap[3]), 32'h3E);
    check("t2_busy", 32'(busy_n), 32'd4);

    // Two events during a status frame: first held, second dropped.
    tx_ready = 1'b0; enable = 1'b1;
    wait_valid();
    check("t3_latency", 32'(w), 32'd21);
    enable = 1'b0; evt_code = 8'h11; evt_req = 1'b1;
    #1;
    check("t3_ack1", 32'({evt_ack, evt_dropped}), 32'b10);
    @(negedge clk);
    evt_code = 8'h22;
    #1;
    check("t3_drop2", 32'({evt_ack, evt_dropped}), 32'b01);
    @(negedge clk);
    evt_req = 1'b0;
    collect(17, 1'b0);
    build_status(pat2);
    verify("t3s", 17);
    status_bus = pat3;

    // Event frame stalls on its header while two period wraps pass; a new event is accepted.
    tx_ready = 1'b0; enable = 1'b1;
    @(negedge clk);
    check("t3e_start", 32'({tx_valid, tx_data}), 32'({1'b1, 8'hA5}));
    evt_code = 8'h55; evt_req = 1'b1;
    #1;
    check("t4_ack_on_free", 32'({evt_ack, evt_dropped}), 32'b10);
    ovr = 0;
    for (int i = 2; i <= 45; i++) begin
      @(negedge clk);
      if (i == 2) evt_req = 1'b0;
      if (status_overrun) ovr++;
    end
    enable = 1'b0;
    check("t4_overrun", 32'(ovr), 32'd1);
    check("t4_stall_hdr", 32'({tx_valid, tx_data}), 32'({1'b1, 8'hA5}));
    collect(4, 1'b0);
    build_evt(8'h11);
    verify("t3e", 4);

    // Both pending after an event frame: status goes first, with random back-pressure.
    enable = 1'b1;
    wait_valid();
    check("t4_stat_first_lat", 32'(w), 32'd1);
    enable = 1'b0;
    collect(17, 1'b1);
    build_status(pat3);
    verify("t5", 17);
    enable = 1'b1;
    wait_valid();
    check("t4_evt_second_lat", 32'(w), 32'd1);
    enable = 1'b0;
    collect(4, 1'b0);
    build_evt(8'h55);
    verify("t4e", 4);

    // Reset while byte 6 of a status frame is on the link, with an event also pending.
    status_bus = pat1; tx_ready = 1'b0; enable = 1'b1;
    wait_valid();
    check("t6_latency", 32'(w), 32'd21);
    enable = 1'b0; evt_code = 8'h77; evt_req = 1'b1;
    #1;
    check("t6_ack", 32'(evt_ack), 32'd1);
    @(negedge clk);
    evt_req = 1'b0;
    collect(5, 1'b0);
    check("t6_len", 32'(cap_n), 32'd5);
    check("t6_b4", 32'(cap[4]), 32'h03);
    check("t6_pre_rst", 32'({tx_valid, tx_data}), 32'({1'b1, 8'h04}));
    rst = 1'b1; evt_req = 1'b1;
    #1;
    check("t6_rst_now", 32'({tx_valid, busy, tx_data}), 32'd0);
    check("t6_rst_ack", 32'(evt_ack), 32'd0);
    evt_req = 1'b0;
    @(negedge clk);
    rst = 1'b0; enable = 1'b1; tx_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (tx_valid || busy) bad++;
    end
    enable = 1'b0;
    check("t6_no_stale", 32'(bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
